// File: rtl/lighting_pkg.sv
// Shared types and constants for the lighting controller: FSM encoding and
// dimming-level geometry.
package lighting_pkg;

    localparam int LEVEL_W = 3;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_ON        = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } light_state_t;

endpackage

// File: rtl/motion_debouncer.sv
// Two-flop synchronizer followed by a stability counter: the output only
// follows the synchronized input once it has held for DEBOUNCE cycles.
module motion_debouncer #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Any sample matching the current output restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dout  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != dout) begin
                if (cnt == CNT_LAST) begin
                    dout <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lighting_ctrl.sv
// Lamp controller: debounced occupancy plus dark/bright hysteresis drive an
// FSM that soft-starts, holds and soft-stops a 3-bit dimming level.
module lighting_ctrl
    import lighting_pkg::*;
#(
    parameter int DEBOUNCE    = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int LUX_ON      = 3,
    parameter int LUX_OFF     = 5,
    parameter int RAMP_DIV    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         luminosity,
    input  logic               motionSensor,
    output logic [LEVEL_W-1:0] level,
    output logic               light,
    output logic               occupied,
    output logic [2:0]         state
);

    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]         LUX_ON_L   = 3'(LUX_ON);
    localparam logic [2:0]         LUX_OFF_L  = 3'(LUX_OFF);

    function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v);
        return (v == LEVEL_MAX) ? v : v + LEVEL_W'(1);
    endfunction

    function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] v);
        return (v == '0) ? v : v - LEVEL_W'(1);
    endfunction

    light_state_t       st;
    light_state_t       st_nx;
    logic [LEVEL_W-1:0] level_nx;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_nx;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nx;
    logic               motion_db;
    logic               dark;
    logic               dark_nx;
    logic               demand;
    logic               step;
    logic               in_ramp;

    motion_debouncer #(
        .DEBOUNCE(DEBOUNCE)
    ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (motionSensor),
        .dout (motion_db)
    );

    // Luminosity between the two thresholds leaves the flag untouched.
    always_comb begin
        dark_nx = dark;
        if (luminosity <= LUX_ON_L) begin
            dark_nx = 1'b1;
        end else if (luminosity >= LUX_OFF_L) begin
            dark_nx = 1'b0;
        end
    end

    assign demand  = motion_db & dark;
    assign step    = (presc == PRESC_LAST);
    assign in_ramp = (st == ST_RAMP_UP) || (st == ST_RAMP_DOWN);

    // Loss of darkness is checked first in every lit state.
    always_comb begin
        st_nx    = st;
        level_nx = level;
        hold_nx  = hold_cnt;
        case (st)
            ST_OFF: begin
                level_nx = '0;
                if (demand) st_nx = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (!dark) begin
                    st_nx = ST_RAMP_DOWN;
                end else if (step) begin
                    level_nx = sat_inc(level);
                    if (level_nx == LEVEL_MAX) st_nx = ST_ON;
                end
            end
            ST_ON: begin
                level_nx = LEVEL_MAX;
                if (!dark) begin
                    st_nx = ST_RAMP_DOWN;
                end else if (!motion_db) begin
                    st_nx   = ST_HOLD;
                    hold_nx = HOLD_LAST;
                end
            end
            ST_HOLD: begin
                if (!dark) begin
                    st_nx = ST_RAMP_DOWN;
                end else if (motion_db) begin
                    st_nx = ST_ON;
                end else if (hold_cnt == '0) begin
                    st_nx = ST_RAMP_DOWN;
                end else begin
                    hold_nx = hold_cnt - HOLD_W'(1);
                end
            end
            ST_RAMP_DOWN: begin
                if (demand) begin
                    st_nx = ST_RAMP_UP;
                end else if (step) begin
                    level_nx = sat_dec(level);
                    if (level_nx == '0) st_nx = ST_OFF;
                end
            end
            default: begin
                st_nx    = ST_OFF;
                level_nx = '0;
            end
        endcase
    end

    // A state change restarts the prescaler so every ramp begins with a full interval.
    always_comb begin
        presc_nx = '0;
        if ((st_nx == st) && in_ramp && !step) begin
            presc_nx = presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_OFF;
            level    <= '0;
            light    <= 1'b0;
            occupied <= 1'b0;
            presc    <= '0;
            hold_cnt <= '0;
            dark     <= 1'b0;
        end else begin
            st       <= st_nx;
            level    <= level_nx;
            light    <= (level_nx != '0);
            occupied <= (st_nx == ST_ON) || (st_nx == ST_HOLD);
            presc    <= presc_nx;
            hold_cnt <= hold_nx;
            dark     <= dark_nx;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_lighting_ctrl.sv
// Scenario bench for lighting_ctrl: expected state/level changes are queued
// with their cycle stamps and matched against every observed output change.
module tb_lighting_ctrl;
    import lighting_pkg::*;

    localparam int DEB  = 2;
    localparam int HOLD = 20;
    localparam int RDIV = 2;
    localparam int LON  = 3;
    localparam int LOFF = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] luminosity = 3'd7;
    logic       motion = 1'b0;
    logic [2:0] level;
    logic       light;
    logic       occupied;
    logic [2:0] state;

    lighting_ctrl #(
        .DEBOUNCE   (DEB),
        .HOLD_CYCLES(HOLD),
        .LUX_ON     (LON),
        .LUX_OFF    (LOFF),
        .RAMP_DIV   (RDIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .luminosity  (luminosity),
        .motionSensor(motion),
        .level       (level),
        .light       (light),
        .occupied    (occupied),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [2:0] lvl;
    } exp_t;

    exp_t q[$];
    logic [2:0] prev_st  = 3'd0;
    logic [2:0] prev_lvl = 3'd0;

    task automatic push(input int c, input logic [2:0] s, input int l);
        exp_t e;
        e.cyc = c;
        e.st  = s;
        e.lvl = 3'(l);
        q.push_back(e);
    endtask

    task automatic push_ramp_up(input int t, input int from);
        push(t, ST_RAMP_UP, from);
        for (int k = 1; k <= 7 - from; k++)
            push(t + RDIV * k, (from + k == 7) ? ST_ON : ST_RAMP_UP, from + k);
    endtask

    task automatic push_ramp_down(input int t, input int from);
        push(t, ST_RAMP_DOWN, from);
        for (int k = 1; k <= from; k++)
            push(t + RDIV * k, (from - k == 0) ? ST_OFF : ST_RAMP_DOWN, from - k);
    endtask

    // Output-change monitor: each change of state/level consumes one expectation.
    initial begin
        exp_t e;
        logic exp_occ;
        forever begin
            @(negedge clk);
            if (mon_en && (state !== prev_st || level !== prev_lvl)) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d state=%0d level=%0d (no change expected)",
                             cyc, state, level);
                end else begin
                    e = q.pop_front();
                    exp_occ = (e.st == ST_ON) || (e.st == ST_HOLD);
                    n_checks++;
                    if (cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL change_cycle got=%0d expected=%0d (state %0d level %0d)",
                                 cyc, e.cyc, e.st, e.lvl);
                    end
                    n_checks++;
                    if (state !== e.st) begin
                        n_fail++;
                        $display("FAIL state cyc=%0d got=%0d expected=%0d", cyc, state, e.st);
                    end
                    n_checks++;
                    if (level !== e.lvl) begin
                        n_fail++;
                        $display("FAIL level cyc=%0d got=%0d expected=%0d", cyc, level, e.lvl);
                    end
                    n_checks++;
                    if (light !== (e.lvl != 3'd0)) begin
                        n_fail++;
                        $display("FAIL light cyc=%0d got=%0b expected=%0b", cyc, light, e.lvl != 3'd0);
                    end
                    n_checks++;
                    if (occupied !== exp_occ) begin
                        n_fail++;
                        $display("FAIL occupied cyc=%0d got=%0b expected=%0b", cyc, occupied, exp_occ);
                    end
                end
            end
            prev_st  = state;
            prev_lvl = level;
        end
    end

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout pending=%0d expected=0 next_cyc=%0d", name, q.size(), q[0].cyc);
            q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (level !== 3'd0 || light !== 1'b0 || occupied !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs level=%0d light=%0b occupied=%0b expected 0/0/0", level, light, occupied);
        end
        n_checks++;
        if (state !== ST_OFF) begin
            n_fail++;
            $display("FAIL reset_state got=%0d expected=%0d", state, ST_OFF);
        end
        n_checks++;
        if (dut.dark !== 1'b0 || dut.motion_db !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_internal dark=%0b motion_db=%0b expected 0/0", dut.dark, dut.motion_db);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic_on();
        int t0;
        @(negedge clk);
        luminosity = 3'd1;
        motion     = 1'b1;
        t0 = cyc;
        push_ramp_up(t0 + 5, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut.motion_db !== 1'b0) begin
            n_fail++;
            $display("FAIL db_early cyc=%0d got=%0b expected=0", cyc, dut.motion_db);
        end
        @(negedge clk);
        n_checks++;
        if (dut.motion_db !== 1'b1) begin
            n_fail++;
            $display("FAIL db_rise cyc=%0d got=%0b expected=1", cyc, dut.motion_db);
        end
        wait_drain(40, "basic_on");
    endtask

    task automatic test_hold_expiry();
        int t0;
        @(negedge clk);
        motion = 1'b0;
        t0 = cyc;
        push(t0 + 5, ST_HOLD, 7);
        push_ramp_down(t0 + 5 + HOLD, 7);
        wait_drain(70, "hold_expiry");
        n_checks++;
        if (state !== ST_OFF || light !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_expiry_end state=%0d light=%0b expected %0d/0", state, light, ST_OFF);
        end
    endtask

    task automatic test_hold_remotion();
        int t1;
        test_basic_on();
        @(negedge clk);
        motion = 1'b0;
        t1 = cyc;
        push(t1 + 5, ST_HOLD, 7);
        push(t1 + 20, ST_ON, 7);
        repeat (15) @(negedge clk);
        motion = 1'b1;
        wait_drain(30, "hold_remotion");
        repeat (10) @(negedge clk);
        n_checks++;
        if (state !== ST_ON || level !== 3'd7) begin
            n_fail++;
            $display("FAIL remotion_stay state=%0d level=%0d expected %0d/7", state, level, ST_ON);
        end
    endtask

    task automatic test_hysteresis();
        int t0;
        int sweep[4] = '{3, 4, 3, 4};
        foreach (sweep[i]) begin
            @(negedge clk);
            luminosity = 3'(sweep[i]);
            repeat (3) @(negedge clk);
        end
        n_checks++;
        if (dut.dark !== 1'b1 || state !== ST_ON) begin
            n_fail++;
            $display("FAIL hyst_sweep dark=%0b state=%0d expected 1/%0d", dut.dark, state, ST_ON);
        end
        @(negedge clk);
        luminosity = 3'd5;
        t0 = cyc;
        push_ramp_down(t0 + 2, 7);
        repeat (2) @(negedge clk);
        luminosity = 3'd4;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut.dark !== 1'b0) begin
            n_fail++;
            $display("FAIL hyst_dark_held got=%0b expected=0", dut.dark);
        end
        wait_drain(30, "hysteresis");
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== ST_OFF || light !== 1'b0) begin
            n_fail++;
            $display("FAIL hyst_end state=%0d light=%0b expected %0d/0", state, light, ST_OFF);
        end
    endtask

    task automatic test_glitch();
        bit rose = 1'b0;
        @(negedge clk);
        motion = 1'b0;
        repeat (8) @(negedge clk);
        luminosity = 3'd1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (dut.dark !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_dark got=%0b expected=1", dut.dark);
        end
        motion = 1'b1;
        @(negedge clk);
        motion = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (dut.motion_db !== 1'b0) rose = 1'b1;
        end
        n_checks++;
        if (rose) begin
            n_fail++;
            $display("FAIL glitch_db got=1 expected=0");
        end
        n_checks++;
        if (level !== 3'd0 || state !== ST_OFF) begin
            n_fail++;
            $display("FAIL glitch_level level=%0d state=%0d expected 0/%0d", level, state, ST_OFF);
        end
    endtask

    task automatic test_ramp_reversal();
        int t1;
        test_basic_on();
        @(negedge clk);
        motion = 1'b0;
        t1 = cyc;
        push(t1 + 5,  ST_HOLD, 7);
        push(t1 + 25, ST_RAMP_DOWN, 7);
        push(t1 + 27, ST_RAMP_DOWN, 6);
        push(t1 + 29, ST_RAMP_DOWN, 5);
        push(t1 + 31, ST_RAMP_DOWN, 4);
        repeat (27) @(negedge clk);
        motion = 1'b1;
        push(t1 + 32, ST_RAMP_UP, 4);
        push(t1 + 34, ST_RAMP_UP, 5);
        push(t1 + 36, ST_RAMP_UP, 6);
        push(t1 + 38, ST_ON, 7);
        wait_drain(30, "ramp_reversal");
    endtask

    task automatic test_reset_mid();
        int t0;
        int t1;
        int t2;
        @(negedge clk);
        motion = 1'b0;
        t1 = cyc;
        push(t1 + 5, ST_HOLD, 7);
        push_ramp_down(t1 + 25, 7);
        wait_drain(70, "pre_reset_off");
        @(negedge clk);
        motion = 1'b1;
        t0 = cyc;
        push(t0 + 5,  ST_RAMP_UP, 0);
        push(t0 + 7,  ST_RAMP_UP, 1);
        push(t0 + 9,  ST_RAMP_UP, 2);
        push(t0 + 11, ST_RAMP_UP, 3);
        repeat (12) @(negedge clk);
        n_checks++;
        if (state !== ST_RAMP_UP || level !== 3'd3 || q.size() != 0) begin
            n_fail++;
            $display("FAIL pre_reset state=%0d level=%0d pending=%0d expected %0d/3/0",
                     state, level, q.size(), ST_RAMP_UP);
            q.delete();
        end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_checks++;
        if (level !== 3'd0 || light !== 1'b0 || occupied !== 1'b0 || state !== ST_OFF) begin
            n_fail++;
            $display("FAIL async_reset level=%0d light=%0b occupied=%0b state=%0d expected 0/0/0/%0d",
                     level, light, occupied, state, ST_OFF);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== ST_OFF || level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_held state=%0d level=%0d expected %0d/0", state, level, ST_OFF);
        end
        rst_n = 1'b1;
        t2 = cyc;
        push_ramp_up(t2 + 5, 0);
        mon_en = 1'b1;
        wait_drain(40, "restart");
    endtask

    initial begin
        test_reset();
        test_basic_on();
        test_hold_expiry();
        test_hold_remotion();
        test_hysteresis();
        test_glitch();
        test_ramp_reversal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
